// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan decoder.
// The glyph table lists the active-high gfedcba patterns for nibbles 0..F.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    localparam int NUM_DIGITS = 8;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph-to-nibble lookup; unknown patterns give nibble 0 with err set.
module seg7_glyph_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic       err_o,
    output logic [3:0] nibble_o
);

    logic [15:0] match_s;

    // Match against every table entry and OR the hit index into the nibble
    always_comb begin
        match_s  = 16'h0000;
        nibble_o = 4'h0;
        for (int i = 0; i < 16; i++) begin
            match_s[i] = (pattern_i == GLYPH_TABLE[i]);
            nibble_o   = nibble_o | (match_s[i] ? 4'(i) : 4'h0);
        end
        err_o = ~(|match_s);
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Passive reader for a multiplexed 8-digit seven-segment bus: waits for each
// digit slot to settle, decodes the glyph and assembles complete 32-bit frames.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter bit CTL_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_ctl,
    input  logic [7:0]  i_disp,
    output logic [31:0] o_value,
    output logic [7:0]  o_dp,
    output logic [7:0]  o_err,
    output logic        o_frame,
    output logic        o_digit_stb,
    output logic [2:0]  o_digit_idx,
    output logic [3:0]  o_digit_val
);

    localparam int              CW         = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_TARGET = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
    localparam logic [7:0]      CTL_IDLE   = CTL_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [7:0]      SEG_IDLE   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [7:0]    ctl_q, disp_q, prev_ctl_q, prev_seg_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    seen_q, seen_d;
    logic [31:0]   digit_q, digit_d;
    logic [7:0]    dp_sh_q, dp_sh_d, err_sh_q, err_sh_d;
    logic [31:0]   value_q, value_d;
    logic [7:0]    dp_q, dp_d, err_q, err_d;
    logic          frame_q, frame_d, stb_q, stb_d;
    logic [2:0]    idx_q, idx_d;
    logic [3:0]    val_q, val_d;

    logic [7:0]    ctl_n_s, seg_n_s, seen_next_s;
    logic [2:0]    idx_s;
    logic          slot_valid_s, same_s, capture_s, glyph_err_s;
    logic [3:0]    glyph_nib_s;

    assign ctl_n_s      = ctl_q ^ {8{CTL_ACTIVE_LOW}};
    assign seg_n_s      = disp_q ^ {8{SEG_ACTIVE_LOW}};
    assign slot_valid_s = $onehot(ctl_n_s);
    assign same_s       = (ctl_n_s == prev_ctl_q) && (seg_n_s == prev_seg_q);

    seg7_glyph_decode u_glyph (
        .pattern_i (seg_n_s[6:0]),
        .err_o     (glyph_err_s),
        .nibble_o  (glyph_nib_s)
    );

    // Encode the one-hot digit select into an index
    always_comb begin
        idx_s = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            idx_s = idx_s | (ctl_n_s[i] ? 3'(i) : 3'd0);
        end
    end

    // Settle FSM, shadow update and frame assembly
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        capture_s   = 1'b0;
        seen_d      = seen_q;
        seen_next_s = seen_q;
        digit_d     = digit_q;
        dp_sh_d     = dp_sh_q;
        err_sh_d    = err_sh_q;
        value_d     = value_q;
        dp_d        = dp_q;
        err_d       = err_q;
        frame_d     = 1'b0;
        stb_d       = 1'b0;
        idx_d       = idx_q;
        val_d       = val_q;

        case (state_q)
            IDLE: begin
                if (slot_valid_s) begin
                    cnt_d   = CNT_ONE;
                    state_d = SETTLE;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (!same_s || !slot_valid_s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_TARGET) begin
                    capture_s = 1'b1;
                    state_d   = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HOLD: begin
                if (!same_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capture_s) begin
            digit_d[idx_s*4 +: 4] = glyph_nib_s;
            dp_sh_d[idx_s]        = seg_n_s[SEG_DP];
            err_sh_d[idx_s]       = glyph_err_s;
            stb_d                 = 1'b1;
            idx_d                 = idx_s;
            val_d                 = glyph_nib_s;
            seen_next_s           = seen_q | 8'(8'b1 << idx_s);
            // The completing digit is folded in before the frame is published
            if (seen_next_s == 8'hFF) begin
                value_d = digit_d;
                dp_d    = dp_sh_d;
                err_d   = err_sh_d;
                frame_d = 1'b1;
                seen_d  = 8'h00;
            end else begin
                seen_d  = seen_next_s;
            end
        end else begin
            seen_d = seen_q;
        end
    end

    // State, input and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ctl_q      <= CTL_IDLE;
            disp_q     <= SEG_IDLE;
            prev_ctl_q <= 8'h00;
            prev_seg_q <= 8'h00;
            state_q    <= IDLE;
            cnt_q      <= '0;
            seen_q     <= 8'h00;
            digit_q    <= 32'h0000_0000;
            dp_sh_q    <= 8'h00;
            err_sh_q   <= 8'h00;
            value_q    <= 32'h0000_0000;
            dp_q       <= 8'h00;
            err_q      <= 8'h00;
            frame_q    <= 1'b0;
            stb_q      <= 1'b0;
            idx_q      <= 3'd0;
            val_q      <= 4'h0;
        end else begin
            ctl_q      <= i_ctl;
            disp_q     <= i_disp;
            prev_ctl_q <= ctl_n_s;
            prev_seg_q <= seg_n_s;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seen_q     <= seen_d;
            digit_q    <= digit_d;
            dp_sh_q    <= dp_sh_d;
            err_sh_q   <= err_sh_d;
            value_q    <= value_d;
            dp_q       <= dp_d;
            err_q      <= err_d;
            frame_q    <= frame_d;
            stb_q      <= stb_d;
            idx_q      <= idx_d;
            val_q      <= val_d;
        end
    end

    assign o_value     = value_q;
    assign o_dp        = dp_q;
    assign o_err       = err_q;
    assign o_frame     = frame_q;
    assign o_digit_stb = stb_q;
    assign o_digit_idx = idx_q;
    assign o_digit_val = val_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: expected digit captures and frames are
// queued as slots are driven and compared when the decoder reports them.
module tb_seg_scan_decoder;
    import seg_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  ctl_pin;
    logic [7:0]  disp_pin;
    logic [31:0] o_value;
    logic [7:0]  o_dp;
    logic [7:0]  o_err;
    logic        o_frame;
    logic        o_digit_stb;
    logic [2:0]  o_digit_idx;
    logic [3:0]  o_digit_val;

    int checks = 0;
    int errors = 0;
    int stb_seen = 0;
    int frame_seen = 0;
    int stb_exp = 0;
    int frame_exp = 0;

    logic [6:0]  dq [$];
    logic [47:0] fq [$];
    logic [6:0]  exp_d;
    logic [47:0] exp_f;

    logic [31:0] m_digit;
    logic [7:0]  m_dp, m_err, m_seen;

    logic [6:0] tb_glyph [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    seg_scan_decoder dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ctl       (ctl_pin),
        .i_disp      (disp_pin),
        .o_value     (o_value),
        .o_dp        (o_dp),
        .o_err       (o_err),
        .o_frame     (o_frame),
        .o_digit_stb (o_digit_stb),
        .o_digit_idx (o_digit_idx),
        .o_digit_val (o_digit_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_capture(input int idx, input logic [3:0] nib,
                                 input logic dp, input logic err);
        dq.push_back({3'(idx), nib});
        stb_exp++;
        m_digit[idx*4 +: 4] = nib;
        m_dp[idx]  = dp;
        m_err[idx] = err;
        m_seen[idx] = 1'b1;
        if (m_seen == 8'hFF) begin
            fq.push_back({m_digit, m_dp, m_err});
            frame_exp++;
            m_seen = 8'h00;
        end
    endtask

    task automatic drive_slot(input int idx, input logic [6:0] glyph,
                              input logic dp, input int cycles);
        @(negedge clk);
        ctl_pin  = ~(8'(8'b1 << idx));
        disp_pin = ~{dp, glyph};
        repeat (cycles - 1) @(negedge clk);
    endtask

    task automatic show_hex(input int idx, input int v, input logic dp,
                            input int cycles, input bit capt);
        if (capt) model_capture(idx, 4'(v), dp, 1'b0);
        drive_slot(idx, tb_glyph[v], dp, cycles);
    endtask

    task automatic show_bad(input int idx, input logic [6:0] glyph, input logic dp);
        model_capture(idx, 4'h0, dp, 1'b1);
        drive_slot(idx, glyph, dp, 10);
    endtask

    task automatic blank(input int cycles);
        @(negedge clk);
        ctl_pin  = 8'hFF;
        disp_pin = 8'hFF;
        repeat (cycles - 1) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        assert ({o_value, o_dp, o_err, o_frame, o_digit_stb, o_digit_idx, o_digit_val} === 63'd0)
        else begin
            errors++;
            $error("FAIL %s observed value=%h dp=%h err=%h frame=%b stb=%b idx=%0d val=%h expected all zero",
                   tag, o_value, o_dp, o_err, o_frame, o_digit_stb, o_digit_idx, o_digit_val);
        end
    endtask

    // Scoreboard: pop and compare whenever the DUT reports a capture or frame
    always @(negedge clk) begin
        if (!rst) begin
            if (o_digit_stb) begin
                stb_seen++;
                checks++;
                assert (dq.size() > 0)
                else begin
                    errors++;
                    $error("FAIL unexpected_stb observed idx=%0d val=%h expected no capture",
                           o_digit_idx, o_digit_val);
                end
                if (dq.size() > 0) begin
                    exp_d = dq.pop_front();
                    checks++;
                    assert ({o_digit_idx, o_digit_val} === exp_d)
                    else begin
                        errors++;
                        $error("FAIL digit observed idx=%0d val=%h expected idx=%0d val=%h",
                               o_digit_idx, o_digit_val, exp_d[6:4], exp_d[3:0]);
                    end
                end
            end
            if (o_frame) begin
                frame_seen++;
                checks++;
                assert (fq.size() > 0)
                else begin
                    errors++;
                    $error("FAIL unexpected_frame observed value=%h expected no frame", o_value);
                end
                if (fq.size() > 0) begin
                    exp_f = fq.pop_front();
                    checks++;
                    assert ({o_value, o_dp, o_err} === exp_f)
                    else begin
                        errors++;
                        $error("FAIL frame observed value=%h dp=%h err=%h expected value=%h dp=%h err=%h",
                               o_value, o_dp, o_err, exp_f[47:16], exp_f[15:8], exp_f[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        m_digit  = 32'h0;
        m_dp     = 8'h00;
        m_err    = 8'h00;
        m_seen   = 8'h00;
        rst      = 1'b1;
        ctl_pin  = 8'hFF;
        disp_pin = 8'hFF;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_initial");
        rst = 1'b0;
        blank(3);

        // Full scan of 1..8 on digits 0..7
        for (int i = 0; i < 8; i++) show_hex(i, i + 1, 1'b0, 10, 1'b1);
        blank(4);

        // Too short to settle
        show_hex(0, 3, 1'b0, 3, 1'b0);
        blank(4);

        // Two lines selected, then blank: neither is a valid slot
        @(negedge clk);
        ctl_pin  = ~8'h03;
        disp_pin = ~{1'b0, tb_glyph[5]};
        repeat (9) @(negedge clk);
        checks++;
        assert (dut.state_q === IDLE)
        else begin
            errors++;
            $error("FAIL multi_hot_state observed %0d expected %0d", dut.state_q, IDLE);
        end
        blank(10);
        checks++;
        assert (dut.state_q === IDLE)
        else begin
            errors++;
            $error("FAIL blank_state observed %0d expected %0d", dut.state_q, IDLE);
        end

        // Unknown glyphs, one with its decimal point lit
        for (int i = 0; i < 8; i++) begin
            if (i == 5)      show_bad(5, 7'h49, 1'b1);
            else if (i == 2) show_bad(2, 7'h76, 1'b0);
            else             show_hex(i, 0, 1'b0, 10, 1'b1);
        end
        blank(4);

        // Digit 3 changes 1 -> A before the frame completes
        for (int i = 0; i < 3; i++) show_hex(i, 0, 1'b0, 10, 1'b1);
        show_hex(3, 1, 1'b0, 10, 1'b1);
        show_hex(3, 10, 1'b0, 10, 1'b1);
        for (int i = 4; i < 8; i++) show_hex(i, 0, 1'b0, 10, 1'b1);
        blank(4);

        // Five digits, then reset while digit 4 is held
        for (int i = 0; i < 5; i++) show_hex(i, 5, 1'b0, 10, 1'b1);
        rst      = 1'b1;
        ctl_pin  = 8'hFF;
        disp_pin = 8'hFF;
        m_digit  = 32'h0;
        m_dp     = 8'h00;
        m_err    = 8'h00;
        m_seen   = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_mid_frame");
        rst = 1'b0;
        blank(3);
        for (int i = 0; i < 8; i++) show_hex(i, 9, 1'b0, 10, 1'b1);
        blank(6);

        checks++;
        assert (dq.size() == 0)
        else begin
            errors++;
            $error("FAIL missing_digits observed pending=%0d expected 0", dq.size());
        end
        checks++;
        assert (fq.size() == 0)
        else begin
            errors++;
            $error("FAIL missing_frames observed pending=%0d expected 0", fq.size());
        end
        checks++;
        assert (stb_seen == stb_exp)
        else begin
            errors++;
            $error("FAIL stb_count observed %0d expected %0d", stb_seen, stb_exp);
        end
        checks++;
        assert (frame_seen == frame_exp)
        else begin
            errors++;
            $error("FAIL frame_count observed %0d expected %0d", frame_seen, frame_exp);
        end
        checks++;
        assert (o_value === 32'h9999_9999)
        else begin
            errors++;
            $error("FAIL final_value observed %h expected %h", o_value, 32'h9999_9999);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Passive reader for the multiplexed 8-digit seven-segment bus (ctl/disp) that bbmips drives.
- Samples the digit-select and segment lines and waits for each digit slot to settle.
- Decodes each glyph back to a hex nibble and assembles full 8-digit frames into a 32-bit value.
- Used on-chip for self-check and readback, and in benches as the display monitor.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is captured (valid range 1..65535).
- CTL_ACTIVE_LOW, 1: 1 means the selected digit line is driven 0.
- SEG_ACTIVE_LOW, 1: 1 means a lit segment is driven 0.

Ports:
- i_clk, in, 1: system clock; all logic on the rising edge.
- i_rst, in, 1: synchronous, active-high reset.
- i_ctl, in, 8: digit-select lines; bit n selects digit n.
- i_disp, in, 8: segment lines {dp,g,f,e,d,c,b,a}.
- o_value, out, 32: last complete frame; digit n occupies bits [4n+3:4n].
- o_dp, out, 8: last frame's decimal-point states, 1 = lit.
- o_err, out, 8: last frame's per-digit flag; 1 = glyph not in the hex table.
- o_frame, out, 1: one-cycle pulse when o_value, o_dp and o_err update.
- o_digit_stb, out, 1: one-cycle pulse for each digit capture.
- o_digit_idx, out, 3: index of the captured digit; valid with o_digit_stb.
- o_digit_val, out, 4: decoded nibble; valid with o_digit_stb, 0 if the glyph is unknown.

Behaviour:
- Input stage:
  - i_ctl and i_disp are registered once.
  - The registered values are normalised to active-high using the polarity parameters.
  - All decisions use the normalised registered pair (ctl_n, seg_n).
- Slot-valid condition: ctl_n is exactly one-hot. Zero-hot (blank) or multi-hot is not valid.
- FSM states:
  - IDLE: if slot valid, load cnt=1 and go to SETTLE; otherwise stay.
  - SETTLE:
    - If the pair differs from the previous cycle or the slot is not valid, go to IDLE.
    - Else if cnt == STABLE_CYCLES, capture and go to HOLD.
    - Else cnt++.
  - HOLD: stay while the pair is unchanged. Any change goes to IDLE. A changed pair that is a valid slot is re-evaluated the following cycle.
- STABLE_CYCLES=1 captures on the first SETTLE cycle.
- Capture latency: a pair first present at the input pins gives o_digit_stb STABLE_CYCLES+2 cycles later (1 input register + IDLE + STABLE_CYCLES-1 counting + capture). Captures happen at most once per stable interval.
- cnt width is $clog2(STABLE_CYCLES+1); it never wraps.
- Glyph decode (gfedcba, active-high) maps to nibbles 0..F:
  - 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71
  - Any other pattern gives nibble 0 and err=1.
  - dp is taken separately from seg_n[7] and ignored for decode.
- On capture:
  - Shadow registers digit[idx], dp[idx] and err[idx] are written.
  - seen[idx] is set.
  - o_digit_stb/idx/val are asserted for one cycle.
  - Recapturing a digit already in seen overwrites its shadow entry; seen is unchanged.
- Frame completion: when seen becomes 8'hFF, including via the current capture, then in the same cycle as that o_digit_stb:
  - o_value, o_dp and o_err load the shadow contents, with the completing digit included.
  - o_frame pulses.
  - seen clears to 0.
  - The shadow registers are retained.
- Reset, including mid-SETTLE or mid-HOLD:
  - FSM goes to IDLE; cnt, seen and the shadow registers clear to 0.
  - o_value=0, o_dp=0, o_err=0, o_frame=0, o_digit_stb=0, o_digit_idx=0, o_digit_val=0.
  - The input registers clear to the inactive levels.
  - The first frame after reset needs all 8 digits.

Decomposition:
- Package seg_pkg holds:
  - the state enum {IDLE, SETTLE, HOLD};
  - the 16-entry glyph constant table;
  - NUM_DIGITS=8;
  - the segment bit-position constants.
- One natural sub-module, seg7_glyph_decode: combinational, 7-bit pattern in, {err, nibble[3:0]} out. It is reusable by the future encoder side.

Test Plan:
1. Scan digits 0..7 showing 1,2,3,4,5,6,7,8 (active-low, 10 cycles each, STABLE_CYCLES=4). Required:
   - 8 o_digit_stb pulses;
   - o_frame on the 8th pulse;
   - o_value=32'h87654321, o_err=0.
2. A digit held for only 3 cycles (< STABLE_CYCLES+1) → no capture, no o_digit_stb.
3. i_ctl with two lines active (ctl_n=8'h03), and also all-off blank → no capture, FSM stays in IDLE.
4. Digit 5 shows 0x49 (unknown) with dp lit, digit 2 shows 0x76, others show 0 → at frame: o_err=8'h24, o_dp=8'h20, o_value nibbles 5 and 2 are 0.
5. Digit 3 updated 1 → A before the frame completes → o_value[15:12]=A, one o_frame only.
6. Assert i_rst after 5 digits are captured, then run a full 8-digit scan of 9s:
   - all outputs are 0 during reset;
   - the first o_frame arrives only after all 8 digits are captured, with o_value=32'h99999999.
